// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: decode->execute packet layout and skid buffer states.
package rv32i_types;

  localparam int ORDER_W = 64;

  typedef struct packed {
    logic [31:0]        inst;
    logic [31:0]        pc;
    logic [ORDER_W-1:0] order;
    logic               alu_m1_sel;
  } id_ex_stage_reg_t;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_FULL  = 2'b10
  } skid_state_t;

endpackage

// File: rtl/pipe_order_check.sv
// Tracks the expected RVFI order of accepted instructions and raises a sticky
// flag on the first out-of-sequence accept.
module pipe_order_check
  import rv32i_types::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               accept,
  input  logic [ORDER_W-1:0] order,
  input  logic               flush,
  input  logic [ORDER_W-1:0] flush_order,
  output logic               order_err
);

  logic [ORDER_W-1:0] expected_reg;
  logic               err_reg;

  // Resynchronise to the observed order so a single gap reports only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expected_reg <= '0;
      err_reg      <= 1'b0;
    end else if (flush) begin
      expected_reg <= flush_order;
    end else if (accept) begin
      expected_reg <= order + ORDER_W'(1);
      if (order != expected_reg) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign order_err = err_reg;

endmodule

// File: rtl/id_ex_skid_buffer.sv
// Execute-side 2-entry skid buffer for decode->execute packets, with flush,
// optional order checking and a bubble counter.
module id_ex_skid_buffer
  import rv32i_types::*;
#(
  parameter bit ORDER_CHECK = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  output logic               id_ready,
  input  id_ex_stage_reg_t   id_stage,
  output logic               ex_valid,
  input  logic               ex_ready,
  output id_ex_stage_reg_t   ex_stage,
  input  logic               flush,
  input  logic [ORDER_W-1:0] flush_order,
  output logic [1:0]         occupancy,
  output logic               order_err,
  output logic [CNT_W-1:0]   bubble_cnt
);

  skid_state_t      state_reg, state_next;
  id_ex_stage_reg_t main_reg;
  id_ex_stage_reg_t skid_reg;
  logic [CNT_W-1:0] bubble_cnt_reg;

  logic accept;
  logic pop;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  // Handshake outputs come straight from the state register.
  assign ex_valid  = (state_reg != SKID_EMPTY);
  assign id_ready  = (state_reg != SKID_FULL);
  assign occupancy = state_reg;
  assign ex_stage  = main_reg;

  assign accept = id_valid & id_ready & ~flush;
  assign pop    = ex_valid & ex_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= SKID_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = SKID_EMPTY;
    end else begin
      case (state_reg)
        SKID_EMPTY: begin
          if (accept) begin
            state_next   = SKID_ONE;
            load_main_in = 1'b1;
          end
        end
        SKID_ONE: begin
          if (accept && pop) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_next = SKID_FULL;
            load_skid  = 1'b1;
          end else if (pop) begin
            state_next = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (pop) begin
            state_next     = SKID_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          state_next = SKID_EMPTY;
        end
      endcase
    end
  end

  // Data registers move only on explicit loads; a flush leaves them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_reg <= '0;
      skid_reg <= '0;
    end else begin
      if (load_main_in) begin
        main_reg <= id_stage;
      end else if (load_main_skid) begin
        main_reg <= skid_reg;
      end
      if (load_skid) begin
        skid_reg <= id_stage;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_reg <= '0;
    end else if (ex_ready && !ex_valid) begin
      bubble_cnt_reg <= bubble_cnt_reg + CNT_W'(1);
    end
  end

  assign bubble_cnt = bubble_cnt_reg;

  generate
    if (ORDER_CHECK) begin : gen_order_check
      pipe_order_check u_order_check (
        .clk         (clk),
        .rst         (rst),
        .accept      (accept),
        .order       (id_stage.order),
        .flush       (flush),
        .flush_order (flush_order),
        .order_err   (order_err)
      );
    end else begin : gen_no_order_check
      assign order_err = 1'b0;
    end
  endgenerate

endmodule
